output_port_arbiter: RTL and testbench



---
 rtl/output_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_output_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : output_port_arbiter
// Brief    : Round-robin, wormhole-locked arbiter of NUM_IN show-ahead flit
//            FIFOs onto one credit-flow-controlled output link.
// Revision : 1.0 - initial release
// ============================================================================
module output_port_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int FLIT_WIDTH = 64,
  parameter int CREDITS    = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_IN*FLIT_WIDTH-1:0]       in_flit,
  input  logic [NUM_IN-1:0]                  in_empty,
  output logic [NUM_IN-1:0]                  in_consume,
  output logic [FLIT_WIDTH-1:0]              out_flit,
  output logic                               out_valid,
  input  logic                               credit_return,
  output logic [$clog2(CREDITS+1)-1:0]       credit_cnt,
  output logic [1:0]                         err
);

  localparam int c_PTR_W = $clog2(NUM_IN);
  localparam int c_CNT_W = $clog2(CREDITS + 1);
  localparam logic [c_CNT_W-1:0] c_CREDITS_MAX = c_CNT_W'(CREDITS);
  localparam logic [c_PTR_W-1:0] c_LAST_IN     = c_PTR_W'(NUM_IN - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_PTR_W-1:0]   r_rr_ptr;
  logic [c_PTR_W-1:0]   r_lock_id;
  logic [c_CNT_W-1:0]   r_credit_cnt;
  logic [1:0]           r_err;

  logic [FLIT_WIDTH-1:0] w_flit [NUM_IN];
  logic [NUM_IN-1:0]     w_head;
  logic [NUM_IN-1:0]     w_eligible;
  logic [NUM_IN-1:0]     w_orphan;
  logic [c_PTR_W-1:0]    w_cand;
  logic [c_PTR_W-1:0]    w_rr_idx;
  logic                  w_rr_found;
  logic                  w_credit_ok;
  logic                  w_send;
  logic [c_PTR_W-1:0]    w_grant;
  logic [c_PTR_W-1:0]    w_grant_next;
  logic [FLIT_WIDTH-1:0] w_sel_flit;
  logic                  w_sel_tail;

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_unpack
      assign w_flit[gi] = in_flit[gi*FLIT_WIDTH +: FLIT_WIDTH];
      assign w_head[gi] = in_flit[gi*FLIT_WIDTH + FLIT_WIDTH - 1];
    end
  endgenerate

  // A non-empty input whose front flit is not a head can never start a packet.
  assign w_eligible = ~in_empty & w_head;
  assign w_orphan   = ~in_empty & ~w_head;

  // Walk offsets from the highest down so the lowest offset from rr_ptr wins.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      w_cand = c_PTR_W'((int'(r_rr_ptr) + k) % NUM_IN);
      if (w_eligible[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end
    end
  end

  assign w_credit_ok = (r_credit_cnt != '0);

  always_comb begin
    w_grant = r_lock_id;
    w_send  = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant = w_rr_idx;
      w_send  = w_credit_ok & w_rr_found;
    end else begin
      w_send  = w_credit_ok & ~in_empty[r_lock_id];
    end
  end

  assign w_sel_flit   = w_flit[w_grant];
  assign w_sel_tail   = w_sel_flit[FLIT_WIDTH-2];
  assign w_grant_next = (w_grant == c_LAST_IN) ? '0 : w_grant + 1'b1;

  // Pop strobe is forced low while reset is asserted, independent of clk.
  always_comb begin
    in_consume = '0;
    if (rst && w_send) begin
      in_consume[w_grant] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_lock_id    <= '0;
      r_credit_cnt <= c_CREDITS_MAX;
      r_err        <= '0;
      out_flit     <= '0;
      out_valid    <= 1'b0;
    end else begin
      if (w_send) begin
        out_flit  <= w_sel_flit;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_send) begin
            if (w_sel_tail) begin
              r_rr_ptr <= w_grant_next;
            end else begin
              r_state   <= S_LOCKED;
              r_lock_id <= w_grant;
            end
          end
        end
        S_LOCKED: begin
          if (w_send && w_sel_tail) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_grant_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Send and return in the same cycle cancel out.
      case ({w_send, credit_return})
        2'b10: r_credit_cnt <= r_credit_cnt - 1'b1;
        2'b01: begin
          if (r_credit_cnt == c_CREDITS_MAX) begin
            r_err[0] <= 1'b1;
          end else begin
            r_credit_cnt <= r_credit_cnt + 1'b1;
          end
        end
        default: r_credit_cnt <= r_credit_cnt;
      endcase

      if ((r_state == S_IDLE) && (|w_orphan)) begin
        r_err[1] <= 1'b1;
      end
    end
  end

  assign credit_cnt = r_credit_cnt;
  assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_output_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_port_arbiter
// Brief    : Directed scoreboard bench for output_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_port_arbiter;

  logic         clk;
  logic         rst;
  logic [255:0] in_flit;
  logic [3:0]   in_empty;
  logic [3:0]   in_consume;
  logic [63:0]  out_flit;
  logic         out_valid;
  logic         credit_return;
  logic [3:0]   credit_cnt;
  logic [1:0]   err;

  output_port_arbiter #(.NUM_IN(4), .FLIT_WIDTH(64), .CREDITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_flit       (in_flit),
    .in_empty      (in_empty),
    .in_consume    (in_consume),
    .out_flit      (out_flit),
    .out_valid     (out_valid),
    .credit_return (credit_return),
    .credit_cnt    (credit_cnt),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [63:0] fifo [4][$];
  logic [63:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          vcount, run_len, max_run;
  logic [3:0]  cons_s, cons_or;
  logic        ov_s;

  function automatic logic [63:0] mk(input logic h, input logic t,
                                     input logic [7:0] id, input logic [7:0] seq);
    return {h, t, 46'd0, id, seq};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (fifo[i].size() > 0) begin
        in_flit[i*64 +: 64] = fifo[i][0];
        in_empty[i]         = 1'b0;
      end else begin
        in_flit[i*64 +: 64] = '0;
        in_empty[i]         = 1'b1;
      end
    end
  endtask

  task automatic clr_stats();
    vcount = 0; run_len = 0; max_run = 0; cons_or = '0;
  endtask

  // Sample at negedge, apply pops just after the following posedge.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    ov_s    = out_valid;
    cons_s  = in_consume;
    cons_or = cons_or | in_consume;
    if (out_valid) begin
      vcount++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (exp_q.size() == 0) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL out_unexpected observed=%h expected=none", out_flit);
        end
      end else begin
        e = exp_q.pop_front();
        check("out_flit", out_flit, e);
      end
    end else begin
      run_len = 0;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (cons_s[i] && fifo[i].size() > 0) void'(fifo[i].pop_front());
    end
    drive();
  endtask

  task automatic refill(input int n);
    credit_return = 1'b1;
    repeat (n) cycle();
    credit_return = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    credit_return = 1'b0;
    in_flit = '0;
    in_empty = '1;
    clr_stats();

    // Reset with all inputs holding head flits
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) begin
        fifo[i].push_back(mk(1'b1, 1'b1, 8'(i), 8'(s)));
      end
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 1'b1, 8'(i), 8'(s)));
    drive();
    repeat (2) cycle();
    check("rst_in_consume", in_consume, 4'b0000);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_flit", out_flit, 64'd0);
    check("rst_credit_cnt", credit_cnt, 4'd8);
    check("rst_err", err, 2'b00);
    rst = 1'b1;

    // Round robin
    clr_stats();
    cycle();
    check("first_grant", cons_s, 4'b0001);
    repeat (12) cycle();
    check("rr_vcount", vcount, 8);
    check("rr_back_to_back", max_run, 8);
    check("rr_exp_drained", exp_q.size(), 0);
    check("rr_credits", credit_cnt, 4'd0);
    refill(8);
    check("refill_8", credit_cnt, 4'd8);

    // Wormhole lock, no bubble
    fifo[1].push_back(mk(1'b1, 1'b0, 8'd1, 8'd0));
    fifo[1].push_back(mk(1'b0, 1'b0, 8'd1, 8'd1));
    fifo[1].push_back(mk(1'b0, 1'b1, 8'd1, 8'd2));
    fifo[2].push_back(mk(1'b1, 1'b1, 8'd2, 8'd0));
    for (int s = 0; s < 4; s++) exp_q.push_back(s < 3 ? fifo[1][s] : fifo[2][0]);
    drive();
    clr_stats();
    repeat (8) cycle();
    check("worm_vcount", vcount, 4);
    check("worm_contiguous", max_run, 4);
    check("worm_exp_drained", exp_q.size(), 0);
    refill(4);

    // Wormhole lock with a bubble after the head
    fifo[1].push_back(mk(1'b1, 1'b0, 8'd1, 8'd10));
    fifo[2].push_back(mk(1'b1, 1'b1, 8'd2, 8'd10));
    exp_q.push_back(mk(1'b1, 1'b0, 8'd1, 8'd10));
    drive();
    clr_stats();
    cycle();
    check("bubble_head_grant", cons_s, 4'b0010);
    cycle();
    check("bubble_no_regrant", cons_s, 4'b0000);
    fifo[1].push_back(mk(1'b0, 1'b0, 8'd1, 8'd11));
    fifo[1].push_back(mk(1'b0, 1'b1, 8'd1, 8'd12));
    exp_q.push_back(mk(1'b0, 1'b0, 8'd1, 8'd11));
    exp_q.push_back(mk(1'b0, 1'b1, 8'd1, 8'd12));
    exp_q.push_back(mk(1'b1, 1'b1, 8'd2, 8'd10));
    drive();
    cycle();
    check("bubble_stall", ov_s, 1'b0);
    repeat (6) cycle();
    check("bubble_vcount", vcount, 4);
    check("bubble_exp_drained", exp_q.size(), 0);
    check("no_err_yet", err, 2'b00);
    refill(4);
    check("refill_4", credit_cnt, 4'd8);

    // Credit exhaustion
    for (int s = 0; s < 10; s++) fifo[0].push_back(mk(1'b1, 1'b1, 8'd0, 8'(s)));
    for (int s = 0; s < 8; s++) exp_q.push_back(mk(1'b1, 1'b1, 8'd0, 8'(s)));
    drive();
    clr_stats();
    repeat (12) cycle();
    check("cred_vcount", vcount, 8);
    check("cred_zero", credit_cnt, 4'd0);
    check("cred_out_idle", ov_s, 1'b0);
    check("cred_fifo_left", fifo[0].size(), 2);
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    check("cred_no_bypass", cons_s, 4'b0000);
    exp_q.push_back(mk(1'b1, 1'b1, 8'd0, 8'd8));
    cycle();
    check("cred_send_next", cons_s, 4'b0001);
    repeat (4) cycle();
    check("cred_one_more", vcount, 9);
    check("cred_zero_again", credit_cnt, 4'd0);
    check("cred_fifo_left1", fifo[0].size(), 1);

    // Drain the last flit, then simultaneous send and return
    exp_q.push_back(mk(1'b1, 1'b1, 8'd0, 8'd9));
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    repeat (3) cycle();
    check("drain_fifo0", fifo[0].size(), 0);
    check("drain_credits", credit_cnt, 4'd0);
    refill(5);
    check("refill_5", credit_cnt, 4'd5);
    fifo[0].push_back(mk(1'b1, 1'b1, 8'd0, 8'd20));
    exp_q.push_back(mk(1'b1, 1'b1, 8'd0, 8'd20));
    drive();
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    check("simul_sent", cons_s, 4'b0001);
    check("simul_cnt", credit_cnt, 4'd5);
    repeat (2) cycle();
    refill(3);
    check("refill_3", credit_cnt, 4'd8);
    credit_return = 1'b1;
    cycle();
    credit_return = 1'b0;
    check("overflow_cnt", credit_cnt, 4'd8);
    check("overflow_err", err, 2'b01);

    // Orphan body flit at input 3
    fifo[3].push_back(mk(1'b0, 1'b0, 8'd3, 8'd0));
    drive();
    clr_stats();
    repeat (4) cycle();
    check("orphan_err", err, 2'b11);
    check("orphan_never_popped", cons_or, 4'b0000);
    check("orphan_fifo", fifo[3].size(), 1);
    fifo[3].delete();
    drive();

    // Async reset while locked
    fifo[2].push_back(mk(1'b1, 1'b0, 8'd2, 8'd30));
    fifo[2].push_back(mk(1'b0, 1'b0, 8'd2, 8'd31));
    exp_q.push_back(mk(1'b1, 1'b0, 8'd2, 8'd30));
    exp_q.push_back(mk(1'b0, 1'b0, 8'd2, 8'd31));
    drive();
    repeat (4) cycle();
    check("locked_credits", credit_cnt, 4'd6);
    fifo[0].push_back(mk(1'b1, 1'b1, 8'd0, 8'd40));
    drive();
    cycle();
    check("locked_holds", cons_s, 4'b0000);
    #2 rst = 1'b0;
    #1;
    check("async_out_valid", out_valid, 1'b0);
    check("async_credits", credit_cnt, 4'd8);
    check("async_err", err, 2'b00);
    check("async_consume", in_consume, 4'b0000);
    rst = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b1, 8'd0, 8'd40));
    cycle();
    check("post_reset_idle", cons_s, 4'b0001);
    repeat (2) cycle();
    check("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
